// File: rtl/aidan_mcnay_prime_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// aidan_mcnay_prime_ctrl_pkg
//   Shared definitions for the trial-division prime controller.
//   Holds:
//   - the controller state encoding (3 bits)
//   - the first trial divisor and its square
// ----------------------------------------------------------------------------
package aidan_mcnay_prime_ctrl_pkg;

    typedef enum logic [2:0] {
        PC_IDLE  = 3'd0,
        PC_CHECK = 3'd1,
        PC_REQ   = 3'd2,
        PC_WAIT  = 3'd3,
        PC_DONE  = 3'd4
    } pc_state_e;

    // Trial division starts at d=2, so the running square starts at 4.
    localparam int unsigned FIRST_DIV = 2;
    localparam int unsigned FIRST_SQ  = 4;

endpackage

// File: rtl/aidan_mcnay_prime_ctrl.sv
// ----------------------------------------------------------------------------
// aidan_mcnay_prime_ctrl
//   Trial-division prime detector. It sits directly upstream of a remainder
//   divider.
//   - It accepts a candidate n.
//   - It asks the divider for n % d for d = 2, 3, ... while d*d <= n.
//   - It reports whether n is prime and the smallest factor of n.
//
//   Ports
//     clk, reset                   clock; synchronous active-low reset
//     num, istream_val/rdy         candidate input stream
//     is_prime, factor,            result output stream (factor = 0 when n
//       ostream_val/rdy              is prime or n < 2)
//     div_opa/opb,                 request to the divider (n, d)
//       div_istream_val/rdy
//     div_result,                  remainder n % d from the divider
//       div_ostream_val/rdy
// ----------------------------------------------------------------------------
module aidan_mcnay_prime_ctrl
    import aidan_mcnay_prime_ctrl_pkg::*;
#(
    parameter int unsigned nbits = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic [nbits-1:0] num,
    input  logic             istream_val,
    output logic             istream_rdy,

    output logic             is_prime,
    output logic [nbits-1:0] factor,
    output logic             ostream_val,
    input  logic             ostream_rdy,

    output logic [nbits-1:0] div_opa,
    output logic [nbits-1:0] div_opb,
    output logic             div_istream_val,
    input  logic             div_istream_rdy,

    input  logic [nbits-1:0] div_result,
    input  logic             div_ostream_val,
    output logic             div_ostream_rdy
);

    localparam int unsigned SQW = 2 * nbits;

    pc_state_e        state_q, state_d;
    logic [nbits-1:0] n_q, n_d;
    logic [nbits-1:0] d_q, d_d;
    logic [SQW-1:0]   sq_q, sq_d;          // invariant: sq_q == d_q * d_q
    logic             is_prime_q, is_prime_d;
    logic [nbits-1:0] factor_q, factor_d;

    // (d+1)^2 = d^2 + 2d + 1. The sum is kept at full 2*nbits width, so it
    // cannot wrap even at d = 2^(nbits/2).
    logic [SQW-1:0]   sq_next;
    assign sq_next = sq_q + {{(nbits-1){1'b0}}, d_q, 1'b1};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= PC_IDLE;
            n_q        <= '0;
            d_q        <= '0;
            sq_q       <= '0;
            is_prime_q <= 1'b0;
            factor_q   <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            d_q        <= d_d;
            sq_q       <= sq_d;
            is_prime_q <= is_prime_d;
            factor_q   <= factor_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        n_d             = n_q;
        d_d             = d_q;
        sq_d            = sq_q;
        is_prime_d      = is_prime_q;
        factor_d        = factor_q;
        istream_rdy     = 1'b0;
        ostream_val     = 1'b0;
        div_istream_val = 1'b0;
        div_ostream_rdy = 1'b0;

        unique case (state_q)
            PC_IDLE: begin
                istream_rdy = 1'b1;
                if (istream_val) begin
                    n_d     = num;
                    d_d     = nbits'(FIRST_DIV);
                    sq_d    = SQW'(FIRST_SQ);
                    state_d = PC_CHECK;
                end
            end
            PC_CHECK: begin
                if (n_q < nbits'(2)) begin
                    is_prime_d = 1'b0;
                    factor_d   = '0;
                    state_d    = PC_DONE;
                end else if (sq_q > {{nbits{1'b0}}, n_q}) begin
                    is_prime_d = 1'b1;
                    factor_d   = '0;
                    state_d    = PC_DONE;
                end else begin
                    state_d = PC_REQ;
                end
            end
            PC_REQ: begin
                div_istream_val = 1'b1;
                if (div_istream_rdy) state_d = PC_WAIT;
            end
            PC_WAIT: begin
                div_ostream_rdy = 1'b1;
                if (div_ostream_val) begin
                    if (div_result == '0) begin
                        is_prime_d = 1'b0;
                        factor_d   = d_q;
                        state_d    = PC_DONE;
                    end else begin
                        d_d     = d_q + nbits'(1);
                        sq_d    = sq_next;
                        state_d = PC_CHECK;
                    end
                end
            end
            PC_DONE: begin
                ostream_val = 1'b1;
                if (ostream_rdy) state_d = PC_IDLE;
            end
            default: state_d = PC_IDLE;
        endcase
    end

    // Operands are driven straight from the registers. They therefore stay
    // stable for as long as REQ holds div_istream_val high.
    assign div_opa  = n_q;
    assign div_opb  = d_q;
    assign is_prime = is_prime_q;
    assign factor   = factor_q;

endmodule

// File: tb/tb_aidan_mcnay_prime_ctrl.sv
module tb_aidan_mcnay_prime_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] num;
    logic        istream_val, istream_rdy;
    logic        is_prime;
    logic [15:0] factor;
    logic        ostream_val, ostream_rdy;
    logic [15:0] div_opa, div_opb;
    logic        div_istream_val, div_istream_rdy;
    logic [15:0] div_result;
    logic        div_ostream_val, div_ostream_rdy;

    int checks = 0;
    int errors = 0;

    logic [16:0] exp_q[$];   // {is_prime, factor}

    // divider model state
    bit          stall = 0;
    int          req_cnt = 0;
    logic [15:0] last_d = 0;

    aidan_mcnay_prime_ctrl #(.nbits(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .num             (num),
        .istream_val     (istream_val),
        .istream_rdy     (istream_rdy),
        .is_prime        (is_prime),
        .factor          (factor),
        .ostream_val     (ostream_val),
        .ostream_rdy     (ostream_rdy),
        .div_opa         (div_opa),
        .div_opb         (div_opb),
        .div_istream_val (div_istream_val),
        .div_istream_rdy (div_istream_rdy),
        .div_result      (div_result),
        .div_ostream_val (div_ostream_val),
        .div_ostream_rdy (div_ostream_rdy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Remainder divider model. Handshakes are sampled at the negedge. The
    // model updates just after the posedge, with optional random stalls.
    initial begin
        bit          req_fire, rsp_fire, rst_s, busy, pend;
        logic [15:0] qa, qb, p_opa, p_opb;
        int          lat;
        busy = 0; pend = 0; lat = 0; qa = 0; qb = 0; p_opa = 0; p_opb = 0;
        div_istream_rdy = 0; div_ostream_val = 0; div_result = 0;
        forever begin
            @(negedge clk);
            req_fire = div_istream_val && div_istream_rdy;
            rsp_fire = div_ostream_val && div_ostream_rdy;
            rst_s    = reset;
            if (pend && div_istream_val) begin
                checks++;
                if (div_opa !== p_opa || div_opb !== p_opb) begin
                    errors++;
                    $display("FAIL req_stable: opa=%0d opb=%0d, required opa=%0d opb=%0d",
                             div_opa, div_opb, p_opa, p_opb);
                end
            end
            pend  = div_istream_val && !req_fire;
            p_opa = div_opa;
            p_opb = div_opb;
            if (req_fire) begin
                qa = div_opa; qb = div_opb;
                req_cnt++;
                last_d = div_opb;
                checks++;
                if (div_opb == 0) begin
                    errors++;
                    $display("FAIL opb_nonzero: opb=%0d, required nonzero", div_opb);
                end
            end
            @(posedge clk); #1;
            if (!rst_s) begin
                busy = 0; div_ostream_val = 0; lat = 0; pend = 0;
            end else begin
                if (rsp_fire) begin div_ostream_val = 0; busy = 0; end
                if (req_fire) begin
                    busy = 1;
                    lat  = stall ? $urandom_range(0, 3) : 0;
                end else if (busy && !div_ostream_val) begin
                    if (lat == 0) begin
                        div_ostream_val = 1;
                        div_result = (qb == 0) ? 16'd0 : qa % qb;
                    end else lat--;
                end
            end
            div_istream_rdy = !busy && (!stall || ($urandom_range(0, 1) == 1));
        end
    end

    // Scoreboard monitor: pops one expected result per output transfer.
    always @(negedge clk) begin
        logic [16:0] e;
        if (reset && ostream_val && ostream_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: is_prime=%0d factor=%0d, required none",
                         is_prime, factor);
            end else begin
                e = exp_q.pop_front();
                if ({is_prime, factor} !== e) begin
                    errors++;
                    $display("FAIL result: is_prime=%0d factor=%0d, required is_prime=%0d factor=%0d",
                             is_prime, factor, e[16], e[15:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // One candidate end to end. hold>0 withholds ostream_rdy in DONE for
    // that many cycles. elat>0 checks the accept-to-ostream_val latency.
    task automatic run(input logic [15:0] n, input logic ep, input logic [15:0] ef,
                       input int ereq, input int hold, input int elat);
        bit got;
        int lat;
        @(posedge clk); #1;
        req_cnt = 0; last_d = 0;
        num = n; istream_val = 1;
        if (hold > 0) ostream_rdy = 0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (istream_rdy) got = 1;
        end
        if (!got) begin
            errors++; checks++;
            $display("FAIL accept_timeout: n=%0d never accepted", n);
            istream_val = 0;
            return;
        end
        exp_q.push_back({ep, ef});
        @(posedge clk); #1;
        istream_val = 0; num = 0;
        lat = 0; got = 0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (ostream_val) got = 1;
        end
        if (!got) begin
            errors++; checks++;
            $display("FAIL result_timeout: n=%0d no ostream_val, required one", n);
            ostream_rdy = 1;
            return;
        end
        if (elat > 0) chk("latency", lat, elat);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                chk("done_hold", {ostream_val, istream_rdy, is_prime, factor},
                    {1'b1, 1'b0, ep, ef});
                @(negedge clk);
            end
            @(posedge clk); #1;
            ostream_rdy = 1;
            @(negedge clk);
        end
        @(negedge clk);
        chk("back_to_idle", {ostream_val, istream_rdy}, 2'b01);
        chk("req_count", req_cnt, ereq);
        if (ereq > 0) chk("last_divisor", last_d, ereq + 1);
    endtask

    initial begin
        bit got;
        reset = 0; num = 0; istream_val = 0; ostream_rdy = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state",
            {ostream_val, div_istream_val, div_ostream_rdy, istream_rdy, is_prime, factor},
            {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0});
        @(posedge clk); #1;
        reset = 1;

        run(16'd0,     1'b0, 16'd0,  0,   0, 2);
        run(16'd1,     1'b0, 16'd0,  0,   0, 2);
        run(16'd2,     1'b1, 16'd0,  0,   0, 2);
        run(16'd3,     1'b1, 16'd0,  0,   0, 2);
        run(16'd4,     1'b0, 16'd2,  1,   0, 0);
        run(16'd91,    1'b0, 16'd7,  6,   0, 0);
        run(16'd97,    1'b1, 16'd0,  8,   0, 0);
        run(16'd65521, 1'b1, 16'd0,  254, 0, 0);
        run(16'd65535, 1'b0, 16'd3,  2,   0, 0);
        run(16'd15,    1'b0, 16'd3,  2,   10, 0);
        stall = 1;
        run(16'd221,   1'b0, 16'd13, 12,  0, 0);
        stall = 0;

        // Abandon 10007 with a reset while the controller waits on a remainder.
        @(posedge clk); #1;
        num = 16'd10007; istream_val = 1;
        @(posedge clk); #1;
        istream_val = 0; num = 0;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (div_ostream_rdy) got = 1;
        end
        if (!got) begin
            errors++; checks++;
            $display("FAIL wait_timeout: never reached WAIT for n=10007");
        end
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_reset",
            {ostream_val, div_istream_val, div_ostream_rdy, istream_rdy, factor},
            {1'b0, 1'b0, 1'b0, 1'b1, 16'd0});
        @(posedge clk); #1;
        reset = 1;
        run(16'd9, 1'b0, 16'd3, 2, 0, 0);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
